// File: rtl/apb4_user_master_if.sv
// APB4 signal bundle between apb4_user_master and the user IP slaves it drives.
interface apb4_if;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb4_user_master.sv
// APB4 initiator: one valid/ready command in, one APB4 transfer out, one response back.
// Define APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb4_user_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    apb4_if.master      apb
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    logic   timeout_hit;

    assign apb.pprot = PPROT_VAL;

    // Gated by reset so the command channel is closed while reset is held.
    assign req_ready_o = (state == IDLE) && rst_n_i;

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts ACCESS cycles that ended without pready.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !apb.pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            apb.pstrb   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        apb.psel   <= 1'b1;
                        apb.paddr  <= req_addr_i;
                        apb.pwrite <= req_write_i;
                        apb.pwdata <= req_wdata_i;
                        apb.pstrb  <= req_write_i ? req_wstrb_i : 4'h0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // A completing pready takes priority over a timeout in the same cycle.
                    if (apb.pready) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= apb.pwrite ? 32'h0 : apb.prdata;
                        rsp_err_o   <= apb.pslverr;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= 32'h0;
                        rsp_err_o   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_user_master.sv
// Directed bench for apb4_user_master; a cycle-window model of each command is checked every cycle.
module tb_apb4_user_master;

    localparam int TO    = 4;
    localparam int NEVER = 1_000_000;
`ifdef APB_MST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i       = 1'b0;
    logic        rst_n_i     = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i  = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    apb4_if apb();

    apb4_user_master #(.TIMEOUT_CYCLES(TO), .PPROT_VAL(3'b010)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .apb         (apb)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Model of the command in flight: accept cycle, wait states, consume cycle and payload.
    bit          m_active = 1'b0;
    int          m_t      = 0;
    int          m_w      = 0;
    int          m_c      = NEVER;
    bit          m_write  = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [3:0]  m_wstrb  = '0;
    logic [31:0] m_rdata  = '0;
    bit          m_err    = 1'b0;

    // Slave answers purely from the timeline: pready in the ACCESS cycle after m_w wait states.
    assign apb.pready  = m_active && (cyc == m_t + 2 + m_w);
    assign apb.prdata  = m_rdata;
    assign apb.pslverr = m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // Every-cycle comparison of the DUT against the window model.
    always @(negedge clk_i) begin : compare
        bit timed_out;
        int acc_end;
        bit e_psel, e_pen, e_rv, e_rdy;
        if (!rst_n_i) begin
            check("rst_psel", apb.psel, 0);
            check("rst_penable", apb.penable, 0);
            check("rst_pwrite", apb.pwrite, 0);
            check("rst_paddr", apb.paddr, 0);
            check("rst_pwdata", apb.pwdata, 0);
            check("rst_pstrb", apb.pstrb, 0);
            check("rst_req_ready", req_ready_o, 0);
            check("rst_rsp_valid", rsp_valid_o, 0);
            check("rst_rsp_rdata", rsp_rdata_o, 0);
            check("rst_rsp_err", rsp_err_o, 0);
        end else begin
            timed_out = TO_EN && (m_w >= TO);
            acc_end   = timed_out ? m_t + 1 + TO : m_t + 2 + m_w;
            e_psel    = m_active && cyc >= m_t + 1 && cyc <= acc_end;
            e_pen     = m_active && cyc >= m_t + 2 && cyc <= acc_end;
            e_rv      = m_active && cyc >= acc_end + 1 && cyc <= m_c;
            e_rdy     = !(m_active && cyc >= m_t + 1 && cyc <= m_c);
            check("psel", apb.psel, e_psel);
            check("penable", apb.penable, e_pen);
            check("rsp_valid", rsp_valid_o, e_rv);
            check("req_ready", req_ready_o, e_rdy);
            check("pprot", apb.pprot, 3'b010);
            if (e_psel) begin
                check("paddr", apb.paddr, m_addr);
                check("pwrite", apb.pwrite, m_write);
                check("pwdata", apb.pwdata, m_wdata);
                check("pstrb", apb.pstrb, m_write ? m_wstrb : 4'h0);
            end
            if (e_rv) begin
                check("rsp_rdata", rsp_rdata_o, (m_write || timed_out) ? 32'h0 : m_rdata);
                check("rsp_err", rsp_err_o, timed_out || m_err);
            end
        end
    end

    int psel_cnt = 0, pen_cnt = 0, nz_strb_cnt = 0, stable_cnt = 0;
    always @(negedge clk_i) begin
        if (apb.psel) psel_cnt++;
        if (apb.penable) pen_cnt++;
        if (apb.psel && apb.pstrb != 4'h0) nz_strb_cnt++;
        if (apb.psel && apb.paddr == 32'h4 && apb.pwdata == 32'hA5A5_5A5A) stable_cnt++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int w, input logic [31:0] rdata, input bit err);
        m_t = cyc; m_w = w; m_c = NEVER;
        m_write = wr; m_addr = addr; m_wdata = wdata; m_wstrb = strb;
        m_rdata = rdata; m_err = err; m_active = 1'b1;
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr;
        req_wdata_i = wdata; req_wstrb_i = strb;
    endtask

    // Issues one command, waits (bounded) for its response, holds it 'hold' cycles, then consumes it.
    task automatic apply_stimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] strb, input int w, input logic [31:0] rdata,
                                  input bit err, input int hold, input bit spam,
                                  output int lat, output logic [31:0] got_rdata, output logic got_err);
        int t0;
        t0  = cyc;
        lat = -1;
        got_rdata = '0;
        got_err   = 1'b0;
        load_model(wr, addr, wdata, strb, w, rdata, err);
        for (int i = 0; i < 64 && lat < 0; i++) begin
            step();
            if (rsp_valid_o) begin
                lat = cyc - t0;
                got_rdata = rsp_rdata_o;
                got_err   = rsp_err_o;
                rsp_ready_i = 1'b0;
            end else if (spam) begin
                req_addr_i  = req_addr_i + 32'h4;
                req_wdata_i = ~req_wdata_i;
                req_write_i = ~req_write_i;
                rsp_ready_i = 1'b1;
            end else begin
                req_valid_i = 1'b0;
            end
        end
        if (lat < 0) check("rsp_within_budget", 0, 1);
        repeat (hold) step();
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        m_c = cyc;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic check_output(input string name, input int lat, input int exp_lat,
                                input logic [31:0] rd, input logic [31:0] exp_rd,
                                input logic er, input logic exp_er);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, er, exp_er);
    endtask

    initial begin : driver
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          p0, e0, s0, z0;

        repeat (3) step();
        check("ready_in_reset", req_ready_o, 0);
        rst_n_i = 1'b1;
        step();
        check("ready_after_reset", req_ready_o, 1);

        $display("[TB] read, zero wait states");
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0000_00FF, 1'b0, 0, 1'b0, lat, rd, er);
        check_output("read_id", lat, 3, rd, 32'hFF, er, 1'b0);

        $display("[TB] write, three wait states");
        p0 = psel_cnt; e0 = pen_cnt; s0 = stable_cnt;
        apply_stimulus(1'b1, 32'h4, 32'hA5A5_5A5A, 4'hF, 3, 32'h1111_1111, 1'b0, 0, 1'b0, lat, rd, er);
        check_output("write_ws3", lat, 6, rd, 32'h0, er, 1'b0);
        check("write_psel_cycles", psel_cnt - p0, 5);
        check("write_penable_cycles", pen_cnt - e0, 4);
        check("write_stable_cycles", stable_cnt - s0, 5);

        $display("[TB] read with strobes and slave error");
        z0 = nz_strb_cnt;
        apply_stimulus(1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, lat, rd, er);
        check_output("read_slverr", lat, 3, rd, 32'hDEAD_BEEF, er, 1'b1);
        check("read_pstrb_zero", nz_strb_cnt - z0, 0);

        $display("[TB] response back-pressure with request spam");
        p0 = psel_cnt;
        apply_stimulus(1'b0, 32'hC, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0, 10, 1'b1, lat, rd, er);
        check_output("backpressure", lat, 4, rd, 32'h0BAD_F00D, er, 1'b0);
        check("backpressure_psel_cycles", psel_cnt - p0, 3);

        $display("[TB] reset during ACCESS");
        load_model(1'b1, 32'h10, 32'h5555_AAAA, 4'hF, 3, 32'h0, 1'b0);
        step();
        req_valid_i = 1'b0;
        step();
        #2;
        rst_n_i  = 1'b0;
        m_active = 1'b0;
        #1;
        check("async_psel", apb.psel, 0);
        check("async_penable", apb.penable, 0);
        check("async_rsp_valid", rsp_valid_o, 0);
        step();
        rst_n_i = 1'b1;
        step();
        apply_stimulus(1'b1, 32'h10, 32'h5555_AAAA, 4'hF, 0, 32'h0, 1'b0, 1, 1'b0, lat, rd, er);
        check_output("after_reset", lat, 3, rd, 32'h0, er, 1'b0);

        $display("[TB] partial-strobe write with slave error");
        apply_stimulus(1'b1, 32'h20, 32'h1234_5678, 4'h3, 2, 32'hFFFF_0000, 1'b1, 0, 1'b0, lat, rd, er);
        check_output("write_strb3", lat, 5, rd, 32'h0, er, 1'b1);

        $display("[TB] slave never ready");
        if (TO_EN) begin
            apply_stimulus(1'b0, 32'h30, 32'h0, 4'h0, NEVER, 32'h7777_7777, 1'b0, 2, 1'b0, lat, rd, er);
            check_output("timeout", lat, 2 + TO, rd, 32'h0, er, 1'b1);
        end else begin
            load_model(1'b0, 32'h30, 32'h0, 4'h0, NEVER, 32'h7777_7777, 1'b0);
            step();
            req_valid_i = 1'b0;
            repeat (100) step();
            check("stuck_psel", apb.psel, 1);
            check("stuck_penable", apb.penable, 1);
            check("stuck_rsp_valid", rsp_valid_o, 0);
            rst_n_i  = 1'b0;
            m_active = 1'b0;
            step();
            rst_n_i = 1'b1;
            step();
        end
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0000_00FF, 1'b0, 0, 1'b0, lat, rd, er);
        check_output("final_read", lat, 3, rd, 32'hFF, er, 1'b0);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
